gsau_issue_sequencer: RTL and testbench

Sequencer between the scoreboard/veggie-file front end and the systolic array inside the GSAU. It accepts one instruction at a time from the scoreboard, fetches its operands from the veggie file, and issues a weight load or an activation+partial-sum push into the array. It tracks the destination register of every in-flight activation in a tag FIFO and pairs each array output with its destination on the way to the WB buffer, with full backpressure.

---
 rtl/gsau_issue_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_gsau_issue_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsau_issue_sequencer.sv
// gsau_issue_sequencer
// Takes one instruction at a time from the scoreboard and fetches its operands
// from the veggie file. It then issues either a weight load or an
// activation+partial-sum push into the systolic array. Each activation's
// destination register is queued in a tag FIFO. The queued tag is paired
// with the matching array result on its way to the WB buffer.

module gsau_issue_sequencer #(
    parameter int DW        = 512,
    parameter int DST_W     = 8,
    parameter int TAG_DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       sb_valid,
    input  logic                       sb_weight,
    input  logic [DST_W-1:0]           sb_vdst,
    output logic                       sb_ready,
    input  logic                       veg_valid,
    input  logic [DW-1:0]              veg_vdata1,
    input  logic [DW-1:0]              veg_vdata2,
    output logic                       veg_ready,
    input  logic                       sa_fifo_has_space,
    output logic [DW-1:0]              sa_array_in,
    output logic [DW-1:0]              sa_array_in_partials,
    output logic                       sa_input_en,
    output logic                       sa_weight_en,
    output logic                       sa_partial_en,
    input  logic                       sa_out_valid,
    input  logic [DW-1:0]              sa_array_output,
    output logic                       sa_output_ready,
    input  logic                       wb_output_ready,
    output logic                       wb_valid,
    output logic [DW-1:0]              wb_psum,
    output logic [DST_W-1:0]           wb_wbdst,
    output logic [$clog2(TAG_DEPTH):0] inflight
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(TAG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              weight_r;
    logic [DST_W-1:0]  vdst_r;
    logic              sb_ready_s;
    logic              veg_ready_s;
    logic              sb_acc_s;
    logic              fetch_acc_s;
    logic              push_s;
    logic              pop_s;
    logic              sa_output_ready_s;
    logic              input_en_r;
    logic              weight_en_r;
    logic [DW-1:0]     array_in_r;
    logic [DW-1:0]     partials_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [DST_W-1:0]  tag_mem_r [TAG_DEPTH];
    logic              wb_valid_r;
    logic [DW-1:0]     wb_psum_r;
    logic [DST_W-1:0]  wb_wbdst_r;

    assign sb_acc_s    = sb_valid && sb_ready_s;
    assign fetch_acc_s = veg_valid && veg_ready_s;
    // The strobe is high exactly in the ISSUE cycle of an activation.
    assign push_s      = input_en_r;
    // A result is never taken without a tag to pair it with.
    assign sa_output_ready_s = (count_r != '0) && (!wb_valid_r || wb_output_ready);
    assign pop_s       = sa_out_valid && sa_output_ready_s;

    // Issue FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Issue FSM next-state and handshake readies
    always_comb begin
        state_nxt_s = state_r;
        sb_ready_s  = 1'b0;
        veg_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sb_ready_s = 1'b1;
                if (sb_valid) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Weight loads wait for the array and the WB register to drain.
                if (weight_r) begin
                    veg_ready_s = (count_r == '0) && !wb_valid_r;
                end else begin
                    veg_ready_s = sa_fifo_has_space && (count_r < FULL_COUNT);
                end
                if (veg_valid && veg_ready_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch instruction kind and destination on scoreboard accept
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            weight_r <= 1'b0;
            vdst_r   <= '0;
        end else if (sb_acc_s) begin
            weight_r <= sb_weight;
            vdst_r   <= sb_vdst;
        end else begin
            weight_r <= weight_r;
            vdst_r   <= vdst_r;
        end
    end

    // Operand rows to the array; held between issues
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            array_in_r <= '0;
            partials_r <= '0;
        end else if (fetch_acc_s) begin
            array_in_r <= veg_vdata1;
            partials_r <= veg_vdata2;
        end else begin
            array_in_r <= array_in_r;
            partials_r <= partials_r;
        end
    end

    // Single-cycle issue strobes, raised for the cycle following operand accept
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            input_en_r  <= 1'b0;
            weight_en_r <= 1'b0;
        end else if (fetch_acc_s) begin
            input_en_r  <= !weight_r;
            weight_en_r <= weight_r;
        end else begin
            input_en_r  <= 1'b0;
            weight_en_r <= 1'b0;
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag FIFO storage
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            tag_mem_r[wr_ptr_r] <= vdst_r;
        end else begin
            tag_mem_r[wr_ptr_r] <= tag_mem_r[wr_ptr_r];
        end
    end

    // WB output register: pair the accepted result with the tag at the head
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_valid_r <= 1'b0;
            wb_psum_r  <= '0;
            wb_wbdst_r <= '0;
        end else if (pop_s) begin
            wb_valid_r <= 1'b1;
            wb_psum_r  <= sa_array_output;
            wb_wbdst_r <= tag_mem_r[rd_ptr_r];
        end else if (wb_output_ready) begin
            wb_valid_r <= 1'b0;
        end else begin
            wb_valid_r <= wb_valid_r;
        end
    end

    assign sb_ready             = sb_ready_s;
    assign veg_ready            = veg_ready_s;
    assign sa_array_in          = array_in_r;
    assign sa_array_in_partials = partials_r;
    assign sa_input_en          = input_en_r;
    assign sa_partial_en        = input_en_r;
    assign sa_weight_en         = weight_en_r;
    assign sa_output_ready      = sa_output_ready_s;
    assign wb_valid             = wb_valid_r;
    assign wb_psum              = wb_psum_r;
    assign wb_wbdst             = wb_wbdst_r;
    assign inflight             = count_r;

endmodule

// File: tb/tb_gsau_issue_sequencer.sv
// Directed testbench for gsau_issue_sequencer.
module tb_gsau_issue_sequencer;

    localparam int DW    = 512;
    localparam int DST_W = 8;
    localparam int LIMIT = 20;

    logic             clk = 1'b0;
    logic             nRST = 1'b1;
    logic             sb_valid = 1'b0;
    logic             sb_weight = 1'b0;
    logic [DST_W-1:0] sb_vdst = '0;
    logic             sb_ready;
    logic             veg_valid = 1'b0;
    logic [DW-1:0]    veg_vdata1 = '0;
    logic [DW-1:0]    veg_vdata2 = '0;
    logic             veg_ready;
    logic             sa_fifo_has_space = 1'b1;
    logic [DW-1:0]    sa_array_in;
    logic [DW-1:0]    sa_array_in_partials;
    logic             sa_input_en;
    logic             sa_weight_en;
    logic             sa_partial_en;
    logic             sa_out_valid = 1'b0;
    logic [DW-1:0]    sa_array_output = '0;
    logic             sa_output_ready;
    logic             wb_output_ready = 1'b1;
    logic             wb_valid;
    logic [DW-1:0]    wb_psum;
    logic [DST_W-1:0] wb_wbdst;
    logic [3:0]       inflight;

    int checks = 0;
    int failures = 0;

    gsau_issue_sequencer #(.DW(DW), .DST_W(DST_W), .TAG_DEPTH(8)) dut (
        .CLK(clk), .nRST(nRST),
        .sb_valid(sb_valid), .sb_weight(sb_weight), .sb_vdst(sb_vdst), .sb_ready(sb_ready),
        .veg_valid(veg_valid), .veg_vdata1(veg_vdata1), .veg_vdata2(veg_vdata2), .veg_ready(veg_ready),
        .sa_fifo_has_space(sa_fifo_has_space), .sa_array_in(sa_array_in),
        .sa_array_in_partials(sa_array_in_partials), .sa_input_en(sa_input_en),
        .sa_weight_en(sa_weight_en), .sa_partial_en(sa_partial_en),
        .sa_out_valid(sa_out_valid), .sa_array_output(sa_array_output),
        .sa_output_ready(sa_output_ready), .wb_output_ready(wb_output_ready),
        .wb_valid(wb_valid), .wb_psum(wb_psum), .wb_wbdst(wb_wbdst), .inflight(inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [31:0] k);
        pat = {16{k ^ 32'hA5A5_5A5A}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard handshake then operand handshake; returns in the ISSUE cycle.
    task automatic issue_to(input logic w, input logic [DST_W-1:0] dst,
                            input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                            output int stall);
        int guard;
        guard = 0;
        sb_valid = 1'b1; sb_weight = w; sb_vdst = dst;
        while (!sb_ready && guard < LIMIT) begin tick(); guard++; end
        tick();
        sb_valid = 1'b0; sb_weight = 1'b0;
        veg_valid = 1'b1; veg_vdata1 = d1; veg_vdata2 = d2;
        stall = 0;
        while (!veg_ready && stall < LIMIT) begin tick(); stall++; end
        tick();
        veg_valid = 1'b0;
        stall = stall + guard;
    endtask

    task automatic test_reset();
        #2 nRST = 1'b0;
        #2;
        checks++; if (sb_ready !== 1'b1) begin failures++; $display("FAIL rst_sb_ready got=%0b exp=1", sb_ready); end
        checks++; if (veg_ready !== 1'b0) begin failures++; $display("FAIL rst_veg_ready got=%0b exp=0", veg_ready); end
        checks++; if (sa_output_ready !== 1'b0) begin failures++; $display("FAIL rst_sa_output_ready got=%0b exp=0", sa_output_ready); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%0b exp=0", wb_valid); end
        checks++; if (wb_wbdst !== 8'h00) begin failures++; $display("FAIL rst_wb_wbdst got=%h exp=00", wb_wbdst); end
        checks++; if (wb_psum !== {DW{1'b0}}) begin failures++; $display("FAIL rst_wb_psum got=%h exp=0", wb_psum); end
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
        checks++; if ({sa_input_en, sa_weight_en, sa_partial_en} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {sa_input_en, sa_weight_en, sa_partial_en}); end
        checks++; if ((sa_array_in | sa_array_in_partials) !== {DW{1'b0}}) begin failures++; $display("FAIL rst_array_in got=%h exp=0", sa_array_in | sa_array_in_partials); end
        @(negedge clk);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_weight_load();
        int stall;
        issue_to(1'b1, 8'h05, pat(1), pat(2), stall);
        checks++; if (stall !== 0) begin failures++; $display("FAIL wl_stall got=%0d exp=0", stall); end
        checks++; if ({sa_weight_en, sa_input_en, sa_partial_en} !== 3'b100) begin failures++; $display("FAIL wl_strobes got=%b exp=100", {sa_weight_en, sa_input_en, sa_partial_en}); end
        checks++; if (sa_array_in !== pat(1)) begin failures++; $display("FAIL wl_array_in got=%h exp=%h", sa_array_in, pat(1)); end
        checks++; if (sb_ready !== 1'b0) begin failures++; $display("FAIL wl_sb_ready_issue got=%0b exp=0", sb_ready); end
        tick();
        checks++; if (sa_weight_en !== 1'b0) begin failures++; $display("FAIL wl_weight_en_after got=%0b exp=0", sa_weight_en); end
        checks++; if (sb_ready !== 1'b1) begin failures++; $display("FAIL wl_sb_ready_idle got=%0b exp=1", sb_ready); end
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL wl_inflight got=%0d exp=0", inflight); end
    endtask

    task automatic test_activations();
        int stall;
        for (int i = 0; i < 3; i++) begin
            issue_to(1'b0, 8'(32'h10 + i), pat(10 + i), pat(20 + i), stall);
            checks++; if (stall !== 0) begin failures++; $display("FAIL act_stall%0d got=%0d exp=0", i, stall); end
            checks++; if ({sa_weight_en, sa_input_en, sa_partial_en} !== 3'b011) begin failures++; $display("FAIL act_strobes%0d got=%b exp=011", i, {sa_weight_en, sa_input_en, sa_partial_en}); end
            checks++; if (inflight !== 4'(i)) begin failures++; $display("FAIL act_inflight_issue%0d got=%0d exp=%0d", i, inflight, i); end
            if (i == 0) begin
                checks++; if (sa_array_in !== pat(10)) begin failures++; $display("FAIL act_array_in got=%h exp=%h", sa_array_in, pat(10)); end
                checks++; if (sa_array_in_partials !== pat(20)) begin failures++; $display("FAIL act_partials got=%h exp=%h", sa_array_in_partials, pat(20)); end
            end
            tick();
            checks++; if (inflight !== 4'(i + 1)) begin failures++; $display("FAIL act_inflight_after%0d got=%0d exp=%0d", i, inflight, i + 1); end
        end
        sa_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sa_array_output = pat(30 + i);
            checks++; if (sa_output_ready !== 1'b1) begin failures++; $display("FAIL act_out_ready%0d got=%0b exp=1", i, sa_output_ready); end
            tick();
            checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL act_wb_valid%0d got=%0b exp=1", i, wb_valid); end
            checks++; if (wb_psum !== pat(30 + i)) begin failures++; $display("FAIL act_wb_psum%0d got=%h exp=%h", i, wb_psum, pat(30 + i)); end
            checks++; if (wb_wbdst !== 8'(32'h10 + i)) begin failures++; $display("FAIL act_wb_dst%0d got=%h exp=%h", i, wb_wbdst, 8'(32'h10 + i)); end
            checks++; if (inflight !== 4'(2 - i)) begin failures++; $display("FAIL act_inflight_pop%0d got=%0d exp=%0d", i, inflight, 2 - i); end
        end
        sa_out_valid = 1'b0;
        checks++; if (sa_output_ready !== 1'b0) begin failures++; $display("FAIL act_out_ready_empty got=%0b exp=0", sa_output_ready); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL act_wb_valid_drop got=%0b exp=0", wb_valid); end
    endtask

    task automatic test_fill();
        int stall;
        for (int i = 0; i < 8; i++) begin
            issue_to(1'b0, 8'(32'h20 + i), pat(40 + i), pat(50 + i), stall);
            checks++; if (stall !== 0) begin failures++; $display("FAIL fill_stall%0d got=%0d exp=0", i, stall); end
            tick();
        end
        checks++; if (inflight !== 4'd8) begin failures++; $display("FAIL fill_inflight got=%0d exp=8", inflight); end
        sb_valid = 1'b1; sb_weight = 1'b0; sb_vdst = 8'h28;
        tick();
        sb_valid = 1'b0;
        veg_valid = 1'b1; veg_vdata1 = pat(48); veg_vdata2 = pat(58);
        checks++; if (veg_ready !== 1'b0) begin failures++; $display("FAIL fill_full_veg_ready0 got=%0b exp=0", veg_ready); end
        tick();
        checks++; if (veg_ready !== 1'b0) begin failures++; $display("FAIL fill_full_veg_ready1 got=%0b exp=0", veg_ready); end
        checks++; if (sa_input_en !== 1'b0) begin failures++; $display("FAIL fill_full_no_issue got=%0b exp=0", sa_input_en); end
        sa_out_valid = 1'b1; sa_array_output = pat(60);
        tick();
        sa_out_valid = 1'b0;
        checks++; if (wb_wbdst !== 8'h20) begin failures++; $display("FAIL fill_first_dst got=%h exp=20", wb_wbdst); end
        checks++; if (inflight !== 4'd7) begin failures++; $display("FAIL fill_inflight_pop got=%0d exp=7", inflight); end
        checks++; if (veg_ready !== 1'b1) begin failures++; $display("FAIL fill_veg_ready_release got=%0b exp=1", veg_ready); end
        tick();
        veg_valid = 1'b0;
        checks++; if (sa_input_en !== 1'b1 || sa_array_in !== pat(48)) begin failures++; $display("FAIL fill_ninth_issue got=%0b/%h exp=1/%h", sa_input_en, sa_array_in, pat(48)); end
        tick();
        checks++; if (inflight !== 4'd8) begin failures++; $display("FAIL fill_inflight_refill got=%0d exp=8", inflight); end
        sa_out_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sa_array_output = pat(61 + i);
            tick();
            checks++; if (wb_wbdst !== 8'(32'h21 + i) || wb_psum !== pat(61 + i)) begin failures++; $display("FAIL fill_drain%0d got=%h exp=%h", i, wb_wbdst, 8'(32'h21 + i)); end
        end
        sa_out_valid = 1'b0;
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL fill_inflight_empty got=%0d exp=0", inflight); end
        tick();
    endtask

    task automatic test_wb_backpressure();
        int stall;
        for (int i = 0; i < 2; i++) begin
            issue_to(1'b0, 8'(32'h30 + i), pat(70 + i), pat(75 + i), stall);
            tick();
        end
        wb_output_ready = 1'b0;
        sa_out_valid = 1'b1; sa_array_output = pat(70);
        tick();
        sa_array_output = pat(71);
        checks++; if (sa_output_ready !== 1'b0) begin failures++; $display("FAIL bp_out_ready got=%0b exp=0", sa_output_ready); end
        tick();
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_psum !== pat(70)) begin failures++; $display("FAIL bp_psum_hold got=%h exp=%h", wb_psum, pat(70)); end
        checks++; if (wb_wbdst !== 8'h30) begin failures++; $display("FAIL bp_dst_hold got=%h exp=30", wb_wbdst); end
        checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL bp_inflight got=%0d exp=1", inflight); end
        wb_output_ready = 1'b1;
        #1;
        checks++; if (sa_output_ready !== 1'b1) begin failures++; $display("FAIL bp_out_ready_release got=%0b exp=1", sa_output_ready); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_psum !== pat(71) || wb_wbdst !== 8'h31) begin failures++; $display("FAIL bp_next got=%h exp=31", wb_wbdst); end
        sa_out_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b0 || inflight !== 4'd0) begin failures++; $display("FAIL bp_drained got=%0b/%0d exp=0/0", wb_valid, inflight); end
    endtask

    task automatic test_weight_after_act();
        int stall;
        for (int i = 0; i < 2; i++) begin
            issue_to(1'b0, 8'(32'h40 + i), pat(78), pat(79), stall);
            tick();
        end
        checks++; if (inflight !== 4'd2) begin failures++; $display("FAIL wa_inflight got=%0d exp=2", inflight); end
        sb_valid = 1'b1; sb_weight = 1'b1; sb_vdst = 8'h07;
        tick();
        sb_valid = 1'b0; sb_weight = 1'b0;
        veg_valid = 1'b1; veg_vdata1 = pat(80); veg_vdata2 = pat(81);
        sa_fifo_has_space = 1'b0;
        #1;
        checks++; if (veg_ready !== 1'b0) begin failures++; $display("FAIL wa_ready_busy2 got=%0b exp=0", veg_ready); end
        sa_out_valid = 1'b1; sa_array_output = pat(82);
        tick();
        checks++; if (inflight !== 4'd1 || veg_ready !== 1'b0) begin failures++; $display("FAIL wa_ready_busy1 got=%0d/%0b exp=1/0", inflight, veg_ready); end
        sa_array_output = pat(83);
        tick();
        checks++; if (inflight !== 4'd0 || wb_valid !== 1'b1 || veg_ready !== 1'b0) begin failures++; $display("FAIL wa_ready_wbpend got=%0d/%0b/%0b exp=0/1/0", inflight, wb_valid, veg_ready); end
        checks++; if (wb_wbdst !== 8'h41) begin failures++; $display("FAIL wa_dst got=%h exp=41", wb_wbdst); end
        sa_out_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b0 || veg_ready !== 1'b1) begin failures++; $display("FAIL wa_ready_drained got=%0b/%0b exp=0/1", wb_valid, veg_ready); end
        tick();
        veg_valid = 1'b0;
        checks++; if ({sa_weight_en, sa_input_en} !== 2'b10 || sa_array_in !== pat(80)) begin failures++; $display("FAIL wa_weight_issue got=%b exp=10", {sa_weight_en, sa_input_en}); end
        tick();
        sb_valid = 1'b1; sb_weight = 1'b0; sb_vdst = 8'h42;
        tick();
        sb_valid = 1'b0;
        veg_valid = 1'b1; veg_vdata1 = pat(84); veg_vdata2 = pat(85);
        checks++; if (veg_ready !== 1'b0) begin failures++; $display("FAIL wa_nospace_ready got=%0b exp=0", veg_ready); end
        tick();
        checks++; if (veg_ready !== 1'b0 || sa_input_en !== 1'b0) begin failures++; $display("FAIL wa_nospace_hold got=%0b/%0b exp=0/0", veg_ready, sa_input_en); end
        sa_fifo_has_space = 1'b1;
        #1;
        checks++; if (veg_ready !== 1'b1) begin failures++; $display("FAIL wa_space_ready got=%0b exp=1", veg_ready); end
        tick();
        veg_valid = 1'b0;
        checks++; if (sa_input_en !== 1'b1) begin failures++; $display("FAIL wa_space_issue got=%0b exp=1", sa_input_en); end
        tick();
        sa_out_valid = 1'b1; sa_array_output = pat(86);
        tick();
        sa_out_valid = 1'b0;
        checks++; if (wb_wbdst !== 8'h42 || wb_psum !== pat(86)) begin failures++; $display("FAIL wa_act_result got=%h exp=42", wb_wbdst); end
        tick();
    endtask

    task automatic test_async_reset();
        int stall;
        for (int i = 0; i < 4; i++) begin
            issue_to(1'b0, 8'(32'h50 + i), pat(88), pat(89), stall);
            tick();
        end
        wb_output_ready = 1'b0;
        sa_out_valid = 1'b1; sa_array_output = pat(90);
        tick();
        sa_out_valid = 1'b0;
        checks++; if (inflight !== 4'd3 || wb_valid !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%0b exp=3/1", inflight, wb_valid); end
        sb_valid = 1'b1; sb_weight = 1'b0; sb_vdst = 8'h54;
        tick();
        sb_valid = 1'b0;
        checks++; if (sb_ready !== 1'b0) begin failures++; $display("FAIL ar_in_fetch got=%0b exp=0", sb_ready); end
        #2 nRST = 1'b0;
        #1;
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL ar_inflight got=%0d exp=0", inflight); end
        checks++; if (wb_valid !== 1'b0 || wb_wbdst !== 8'h00) begin failures++; $display("FAIL ar_wb got=%0b/%h exp=0/00", wb_valid, wb_wbdst); end
        checks++; if ({sa_input_en, sa_weight_en, sa_partial_en} !== 3'b000) begin failures++; $display("FAIL ar_strobes got=%b exp=000", {sa_input_en, sa_weight_en, sa_partial_en}); end
        checks++; if (sb_ready !== 1'b1 || veg_ready !== 1'b0 || sa_output_ready !== 1'b0) begin failures++; $display("FAIL ar_readies got=%0b%0b%0b exp=100", sb_ready, veg_ready, sa_output_ready); end
        #2 nRST = 1'b1;
        wb_output_ready = 1'b1;
        tick();
        issue_to(1'b1, 8'h09, pat(91), pat(92), stall);
        checks++; if (stall !== 0 || sa_weight_en !== 1'b1 || sa_array_in !== pat(91)) begin failures++; $display("FAIL ar_recover got=%0d/%0b exp=0/1", stall, sa_weight_en); end
        tick();
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_activations();
        test_fill();
        test_wb_backpressure();
        test_weight_after_act();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
